// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared state encodings and line geometry for the data cache
package cache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REFILL = 2'd1,
        ST_WRITE  = 2'd2
    } state_t;

    localparam int WORDS_PER_BLOCK_DEF = 4;
    localparam int OFS_W_DEF           = $clog2(WORDS_PER_BLOCK_DEF);

endpackage

// File: rtl/dcache_controller_if.sv
// rtl/dcache_controller_if.sv - pipeline, memory and array-control signals of the data cache
interface dcache_controller_if #(
    parameter int OFS_W = 2
);
    logic             MemReadM;
    logic             MemWriteM;
    logic             CacheHitM;
    logic             mem_ready;
    logic             StallCache;
    logic             mem_req;
    logic             mem_we;
    logic [OFS_W-1:0] refill_word;
    logic             refill_we;
    logic             tag_we;
    logic             cache_wr_en;

    modport slave (
        input  MemReadM, MemWriteM, CacheHitM, mem_ready,
        output StallCache, mem_req, mem_we, refill_word, refill_we, tag_we, cache_wr_en
    );

    modport master (
        output MemReadM, MemWriteM, CacheHitM, mem_ready,
        input  StallCache, mem_req, mem_we, refill_word, refill_we, tag_we, cache_wr_en
    );
endinterface

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - W-bit event counter that sticks at all-ones
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/dcache_controller.sv
// rtl/dcache_controller.sv - sequencing FSM for the write-through, no-write-allocate data cache
module dcache_controller
    import cache_pkg::*;
#(
    parameter int WORDS_PER_BLOCK = WORDS_PER_BLOCK_DEF,
    parameter int OFS_W           = $clog2(WORDS_PER_BLOCK),
    parameter int CNT_W           = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    dcache_controller_if.slave    bus,
    output logic [CNT_W-1:0]      read_hits,
    output logic [CNT_W-1:0]      read_misses,
    output logic [CNT_W-1:0]      writes
);

    state_t           state, state_n;
    logic [OFS_W-1:0] beat, beat_n;
    logic             last_beat;
    logic             inc_hit, inc_miss, inc_wr;
    logic             stall, req, we, rwe, twe, cwe;
    logic [OFS_W-1:0] rword;

    assign last_beat = (beat == OFS_W'(WORDS_PER_BLOCK - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            beat  <= '0;
        end else begin
            state <= state_n;
            beat  <= beat_n;
        end
    end

    always_comb begin
        state_n  = state;
        beat_n   = beat;
        stall    = 1'b0;
        req      = 1'b0;
        we       = 1'b0;
        rword    = '0;
        rwe      = 1'b0;
        twe      = 1'b0;
        cwe      = 1'b0;
        inc_hit  = 1'b0;
        inc_miss = 1'b0;
        inc_wr   = 1'b0;
        // Everything stays low while rst is held, combinational outputs included.
        if (!rst) begin
            case (state)
                ST_IDLE: begin
                    if (bus.MemWriteM) begin
                        stall   = 1'b1;
                        req     = 1'b1;
                        we      = 1'b1;
                        cwe     = bus.CacheHitM;
                        state_n = ST_WRITE;
                    end else if (bus.MemReadM && !bus.CacheHitM) begin
                        stall   = 1'b1;
                        req     = 1'b1;
                        beat_n  = '0;
                        state_n = ST_REFILL;
                    end else if (bus.MemReadM) begin
                        inc_hit = 1'b1;
                    end
                end
                ST_REFILL: begin
                    stall = 1'b1;
                    req   = 1'b1;
                    rword = beat;
                    if (bus.mem_ready) begin
                        rwe    = 1'b1;
                        beat_n = beat + 1'b1;
                        if (last_beat) begin
                            twe      = 1'b1;
                            beat_n   = '0;
                            inc_miss = 1'b1;
                            state_n  = ST_IDLE;
                        end
                    end
                end
                ST_WRITE: begin
                    req   = 1'b1;
                    we    = 1'b1;
                    stall = !bus.mem_ready;
                    if (bus.mem_ready) begin
                        inc_wr  = 1'b1;
                        state_n = ST_IDLE;
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    assign bus.StallCache  = stall;
    assign bus.mem_req     = req;
    assign bus.mem_we      = we;
    assign bus.refill_word = rword;
    assign bus.refill_we   = rwe;
    assign bus.tag_we      = twe;
    assign bus.cache_wr_en = cwe;

    sat_counter #(.W(CNT_W)) u_read_hits   (.clk(clk), .rst(rst), .inc(inc_hit),  .count(read_hits));
    sat_counter #(.W(CNT_W)) u_read_misses (.clk(clk), .rst(rst), .inc(inc_miss), .count(read_misses));
    sat_counter #(.W(CNT_W)) u_writes      (.clk(clk), .rst(rst), .inc(inc_wr),   .count(writes));

endmodule

// File: tb/tb_dcache_controller.sv
// tb/tb_dcache_controller.sv - scoreboard bench for dcache_controller
module tb_dcache_controller;

    logic clk = 1'b0;
    logic rst;
    logic rst2;
    always #5 clk = ~clk;

    dcache_controller_if #(.OFS_W(2)) bus  ();
    dcache_controller_if #(.OFS_W(2)) bus2 ();

    logic [15:0] read_hits, read_misses, writes;
    logic [1:0]  sat_hits, sat_misses, sat_writes;

    dcache_controller #(.WORDS_PER_BLOCK(4), .OFS_W(2), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .read_hits(read_hits), .read_misses(read_misses), .writes(writes)
    );

    dcache_controller #(.WORDS_PER_BLOCK(4), .OFS_W(2), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst2), .bus(bus2),
        .read_hits(sat_hits), .read_misses(sat_misses), .writes(sat_writes)
    );

    typedef struct {
        string      name;
        logic [7:0] v;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    // {stall, req, we, refill_word[1:0], refill_we, tag_we, cache_wr_en}
    function automatic logic [7:0] ev(input logic s, input logic q, input logic w,
                                      input logic [1:0] rw, input logic rwe,
                                      input logic twe, input logic cwe);
        return {s, q, w, rw, rwe, twe, cwe};
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t       e;
            logic [7:0] act;
            e   = exp_q.pop_front();
            act = {bus.StallCache, bus.mem_req, bus.mem_we, bus.refill_word,
                   bus.refill_we, bus.tag_we, bus.cache_wr_en};
            n_cmp++;
            if (act !== e.v) begin
                n_fail++;
                $display("FAIL %s: outputs got %b expected %b", e.name, act, e.v);
            end
        end
    end

    task automatic cyc(input logic r, input logic w, input logic h, input logic rdy,
                       input logic [7:0] e, input string nm);
        bus.MemReadM  = r;
        bus.MemWriteM = w;
        bus.CacheHitM = h;
        bus.mem_ready = rdy;
        exp_q.push_back('{nm, e});
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, ev(0,0,0,2'd0,0,0,0), "reset");
        rst = 1'b0;
    endtask

    initial begin
        rst  = 1'b1;
        rst2 = 1'b1;
        bus.MemReadM = 1'b1; bus.MemWriteM = 1'b0; bus.CacheHitM = 1'b0; bus.mem_ready = 1'b0;
        bus2.MemReadM = 1'b1; bus2.MemWriteM = 1'b0; bus2.CacheHitM = 1'b1; bus2.mem_ready = 1'b0;
        @(posedge clk);
        #1;

        // reset held with a pending miss
        cyc(1, 0, 0, 0, ev(0,0,0,2'd0,0,0,0), "rst_hold0");
        cyc(1, 0, 0, 0, ev(0,0,0,2'd0,0,0,0), "rst_hold1");
        chk("rst_read_hits", read_hits, 16'd0);
        chk("rst_read_misses", read_misses, 16'd0);
        chk("rst_writes", writes, 16'd0);
        rst = 1'b0;
        cyc(1, 0, 0, 0, ev(1,1,0,2'd0,0,0,0), "rst_release");

        // read hits
        do_reset();
        for (int i = 0; i < 3; i++) cyc(1, 0, 1, 0, ev(0,0,0,2'd0,0,0,0), "read_hit");
        chk("hit_count", read_hits, 16'd3);

        // read miss, memory always ready
        do_reset();
        cyc(1, 0, 0, 1, ev(1,1,0,2'd0,0,0,0), "miss_idle");
        for (int b = 0; b < 4; b++)
            cyc(1, 0, 0, 1, ev(1,1,0,2'(b),1,(b == 3),0), "miss_beat");
        cyc(1, 0, 1, 1, ev(0,0,0,2'd0,0,0,0), "miss_rehit");
        chk("miss_read_misses", read_misses, 16'd1);
        chk("miss_read_hits", read_hits, 16'd1);

        // read miss, memory ready every third cycle
        do_reset();
        cyc(1, 0, 0, 0, ev(1,1,0,2'd0,0,0,0), "slow_idle");
        for (int b = 0; b < 4; b++) begin
            cyc(1, 0, 0, 0, ev(1,1,0,2'(b),0,0,0), "slow_wait");
            cyc(1, 0, 0, 0, ev(1,1,0,2'(b),0,0,0), "slow_wait");
            cyc(1, 0, 0, 1, ev(1,1,0,2'(b),1,(b == 3),0), "slow_beat");
        end
        cyc(0, 0, 0, 0, ev(0,0,0,2'd0,0,0,0), "slow_done");
        chk("slow_read_misses", read_misses, 16'd1);

        // store hit then store miss, two wait cycles each
        do_reset();
        for (int k = 0; k < 2; k++) begin
            logic h;
            h = (k == 0);
            cyc(0, 1, h, 0, ev(1,1,1,2'd0,0,0,h), "store_idle");
            cyc(0, 1, h, 0, ev(1,1,1,2'd0,0,0,0), "store_wait");
            cyc(0, 1, h, 0, ev(1,1,1,2'd0,0,0,0), "store_wait");
            cyc(0, 1, h, 1, ev(0,1,1,2'd0,0,0,0), "store_ready");
            cyc(0, 0, 0, 0, ev(0,0,0,2'd0,0,0,0), "store_done");
            chk("store_writes", writes, 16'(k + 1));
        end

        // write wins when both strobes are high
        do_reset();
        cyc(1, 1, 0, 0, ev(1,1,1,2'd0,0,0,0), "both_idle");
        cyc(1, 1, 0, 1, ev(0,1,1,2'd0,0,0,0), "both_ready");
        chk("both_writes", writes, 16'd1);
        chk("both_misses", read_misses, 16'd0);

        // reset abandons a refill at beat 2
        do_reset();
        cyc(1, 0, 0, 1, ev(1,1,0,2'd0,0,0,0), "abort_idle");
        cyc(1, 0, 0, 1, ev(1,1,0,2'd0,1,0,0), "abort_b0");
        cyc(1, 0, 0, 1, ev(1,1,0,2'd1,1,0,0), "abort_b1");
        cyc(1, 0, 0, 0, ev(1,1,0,2'd2,0,0,0), "abort_b2");
        rst = 1'b1;
        cyc(1, 0, 0, 1, ev(0,0,0,2'd0,0,0,0), "abort_rst");
        rst = 1'b0;
        cyc(0, 0, 0, 1, ev(0,0,0,2'd0,0,0,0), "abort_idle_after");
        chk("abort_misses", read_misses, 16'd0);
        cyc(1, 0, 0, 0, ev(1,1,0,2'd0,0,0,0), "abort_restart");
        do_reset();

        // saturation on a 2-bit counter instance
        rst2 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("sat_two", 16'(sat_hits), 16'd2);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("sat_four", 16'(sat_hits), 16'd3);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("sat_six", 16'(sat_hits), 16'd3);

        @(negedge clk);
        @(posedge clk); #1;
        chk("queue_drained", 16'(exp_q.size()), 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
